// File: rtl/alu_pkg.sv
// Opcode set, opcode classification helpers and FSM state encoding shared by the
// ALU operand arbiter and its sub-blocks.
package alu_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: is_legal_op = 1'b1;
            default:                                       is_legal_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant. prio names the requester that wins when both are
// valid; a lone valid requester always wins.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/alu_op_arbiter.sv
// Shares one ALU_32 between two requesters: round-robin accept, operand hold for
// the op latency, then a held response carrying result, requester id and error flag.
module alu_op_arbiter
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int MD_LAT  = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_ctrl,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_ctrl,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [4:0]  alu_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [63:0] alu_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_data,
    output logic        rsp_err
);

    localparam int MAX_LAT = (ALU_LAT > MD_LAT) ? ALU_LAT : MD_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;
    localparam logic [CW-1:0] ALU_CNT = CW'(ALU_LAT - 1);
    localparam logic [CW-1:0] MD_CNT  = CW'(MD_LAT - 1);

    state_e        state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          id_q, id_d;
    logic [4:0]    ctrl_q, ctrl_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    alu_ctrl_q, alu_ctrl_d;
    logic [63:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    logic [1:0]    grant;
    logic          sel;
    logic [4:0]    sel_ctrl;

    // rr_ptr holds the requester favoured on a tie; it flips to the other side
    // each time a response retires, so req0 leads straight out of reset.
    rr_arbiter_2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .prio  (rr_ptr_q),
        .grant (grant)
    );

    assign req0_ready = (state_q == ST_IDLE) && clr && grant[0];
    assign req1_ready = (state_q == ST_IDLE) && clr && grant[1];

    assign sel      = grant[1];
    assign sel_ctrl = sel ? req1_ctrl : req0_ctrl;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        ctrl_d     = ctrl_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        alu_ctrl_d = alu_ctrl_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    id_d   = sel;
                    ctrl_d = sel_ctrl;
                    a_d    = sel ? req1_a : req0_a;
                    b_d    = sel ? req1_b : req0_b;
                    if (is_legal_op(sel_ctrl)) begin
                        state_d    = ST_BUSY;
                        cnt_d      = is_muldiv(sel_ctrl) ? MD_CNT : ALU_CNT;
                        alu_ctrl_d = sel_ctrl;
                    end else begin
                        state_d    = ST_RESP;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    alu_ctrl_d = OP_NOP;
                    rsp_data_d = alu_c;
                    rsp_err_d  = (ctrl_q == OP_DIV) && (b_q == '0);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = ~id_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                alu_ctrl_d = OP_NOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 1'b0;
            id_q       <= 1'b0;
            ctrl_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            alu_ctrl_q <= OP_NOP;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            ctrl_q     <= ctrl_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            alu_ctrl_q <= alu_ctrl_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign alu_ctrl  = alu_ctrl_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule
